// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP test-pattern source.
package cam_pkg;

    typedef enum logic [1:0] {
        PatBars    = 2'd0,
        PatRamp    = 2'd1,
        PatSolid   = 2'd2,
        PatChecker = 2'd3
    } pattern_e;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } state_e;

    localparam logic [15:0] BarWhite   = 16'hFFFF;
    localparam logic [15:0] BarYellow  = 16'hFFE0;
    localparam logic [15:0] BarCyan    = 16'h07FF;
    localparam logic [15:0] BarGreen   = 16'h07E0;
    localparam logic [15:0] BarMagenta = 16'hF81F;
    localparam logic [15:0] BarRed     = 16'hF800;
    localparam logic [15:0] BarBlue    = 16'h001F;
    localparam logic [15:0] BarBlack   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BarWhite;
            3'd1:    c = BarYellow;
            3'd2:    c = BarCyan;
            3'd3:    c = BarGreen;
            3'd4:    c = BarMagenta;
            3'd5:    c = BarRed;
            3'd6:    c = BarBlue;
            default: c = BarBlack;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/camera_dvp_source_if.sv
// DVP output bundle: pixel clock, syncs, data byte and end-of-frame pulse.
interface camera_dvp_source_if;
    logic       pclk_out;
    logic       vs_out;
    logic       hs_out;
    logic [7:0] data_out;
    logic       frame_done_out;

    modport source (output pclk_out, vs_out, hs_out, data_out, frame_done_out);
    modport sink   (input  pclk_out, vs_out, hs_out, data_out, frame_done_out);
endinterface

// File: rtl/dvp_pattern_gen.sv
// Combinational RGB565 test-pattern pixel for coordinate (x, y).
module dvp_pattern_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320
) (
    input  pattern_e    i_pattern,
    input  logic [15:0] i_x,
    input  logic [15:0] i_y,
    input  logic        i_fc,
    input  logic [15:0] i_color,
    output logic [15:0] o_pixel
);
    // Guard against zero-width bars on very narrow frames.
    localparam int unsigned BarW = (H_ACTIVE / 8 == 0) ? 1 : H_ACTIVE / 8;

    logic [15:0] w_bar_idx;
    logic [15:0] w_ramp;

    always_comb begin
        w_bar_idx = 16'(32'(i_x) / BarW);
        w_ramp    = 16'(32'(i_x) + 32'(i_y) * H_ACTIVE);
        o_pixel   = '0;
        unique case (i_pattern)
            PatBars:    o_pixel = bar_color((w_bar_idx > 16'd7) ? 3'd7 : w_bar_idx[2:0]);
            PatRamp:    o_pixel = w_ramp;
            PatSolid:   o_pixel = i_color;
            PatChecker: o_pixel = (i_x[3] ^ i_y[3] ^ i_fc) ? 16'hFFFF : 16'h0000;
            default:    o_pixel = '0;
        endcase
    end
endmodule

// File: rtl/camera_dvp_source.sv
// OV5640-style DVP transmitter: pclk divider, line/frame counters, sync FSM and
// registered byte-serial RGB565 output from an internal pattern generator.
module camera_dvp_source
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 320,
    parameter int unsigned V_ACTIVE = 240,
    parameter int unsigned H_BLANK  = 64,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 4,
    parameter int unsigned V_FRONT  = 4,
    parameter int unsigned PCLK_DIV = 2
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       en_in,
    input  logic [1:0]                 pattern_in,
    input  logic [15:0]                color_in,
    camera_dvp_source_if.source        dvp
);
    localparam int unsigned LineLen  = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned FrameLen = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
    localparam int unsigned ActStart = V_SYNC + V_BACK;
    localparam int unsigned ActEnd   = ActStart + V_ACTIVE;
    localparam int unsigned BcW      = $clog2(LineLen + 1);
    localparam int unsigned LcW      = $clog2(FrameLen + 1);
    localparam int unsigned DivW     = $clog2(PCLK_DIV + 1);

    // Phase is a pure function of the frame line, so zero-length phases vanish.
    function automatic state_e phase_of(input int unsigned line);
        if (line < V_SYNC)   return StVsync;
        if (line < ActStart) return StVback;
        if (line < ActEnd)   return StActive;
        return StVfront;
    endfunction

    logic [DivW-1:0] r_div;
    logic            r_pclk;
    state_e          r_state;
    logic [BcW-1:0]  r_bc;
    logic [LcW-1:0]  r_lc;
    pattern_e        r_pat;
    logic [15:0]     r_color;
    logic            r_fc;
    logic            r_vs;
    logic            r_hs;
    logic [7:0]      r_data;
    logic            r_fd;

    logic            w_div_end;
    logic            w_fall;
    state_e          w_state_d;
    logic [BcW-1:0]  w_bc_d;
    logic [LcW-1:0]  w_lc_d;
    logic            w_latch;
    logic            w_last;
    pattern_e        w_pat_d;
    logic [15:0]     w_color_d;
    logic            w_fc_d;
    logic [15:0]     w_x;
    logic [15:0]     w_y;
    logic [15:0]     w_pixel;
    logic            w_hs_d;
    logic [7:0]      w_data_d;

    assign w_div_end = (r_div == DivW'(PCLK_DIV - 1));
    assign w_fall    = w_div_end & r_pclk;

    always_comb begin
        w_state_d = r_state;
        w_bc_d    = r_bc;
        w_lc_d    = r_lc;
        w_latch   = 1'b0;
        w_last    = 1'b0;
        if (r_state == StIdle) begin
            if (en_in) begin
                w_bc_d    = '0;
                w_lc_d    = '0;
                w_state_d = phase_of(0);
                w_latch   = 1'b1;
            end
        end else if (r_bc == BcW'(LineLen - 1)) begin
            w_bc_d = '0;
            if (r_lc == LcW'(FrameLen - 1)) begin
                w_last = 1'b1;
                w_lc_d = '0;
                if (en_in) begin
                    w_state_d = phase_of(0);
                    w_latch   = 1'b1;
                end else begin
                    w_state_d = StIdle;
                end
            end else begin
                w_lc_d    = r_lc + 1'b1;
                w_state_d = phase_of(32'(w_lc_d));
            end
        end else begin
            w_bc_d = r_bc + 1'b1;
        end
    end

    assign w_pat_d   = w_latch ? pattern_e'(pattern_in) : r_pat;
    assign w_color_d = w_latch ? color_in : r_color;
    assign w_fc_d    = r_fc ^ w_last;
    assign w_x       = 16'(32'(w_bc_d) >> 1);
    assign w_y       = 16'(32'(w_lc_d) - ActStart);
    assign w_hs_d    = (w_state_d == StActive) && (32'(w_bc_d) < 2 * H_ACTIVE);
    assign w_data_d  = !w_hs_d ? 8'h00 : (w_bc_d[0] ? w_pixel[7:0] : w_pixel[15:8]);

    dvp_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern_gen (
        .i_pattern (w_pat_d),
        .i_x       (w_x),
        .i_y       (w_y),
        .i_fc      (w_fc_d),
        .i_color   (w_color_d),
        .o_pixel   (w_pixel)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_div   <= '0;
            r_pclk  <= 1'b0;
            r_state <= StIdle;
            r_bc    <= '0;
            r_lc    <= '0;
            r_pat   <= PatBars;
            r_color <= '0;
            r_fc    <= 1'b0;
            r_vs    <= 1'b0;
            r_hs    <= 1'b0;
            r_data  <= '0;
            r_fd    <= 1'b0;
        end else begin
            r_div <= w_div_end ? '0 : r_div + 1'b1;
            if (w_div_end) r_pclk <= ~r_pclk;
            r_fd <= w_fall & w_last;
            // Everything the receiver sees moves only on pclk falling edges.
            if (w_fall) begin
                r_state <= w_state_d;
                r_bc    <= w_bc_d;
                r_lc    <= w_lc_d;
                r_pat   <= w_pat_d;
                r_color <= w_color_d;
                r_fc    <= w_fc_d;
                r_vs    <= (w_state_d == StVsync);
                r_hs    <= w_hs_d;
                r_data  <= w_data_d;
            end
        end
    end

    assign dvp.pclk_out       = r_pclk;
    assign dvp.vs_out         = r_vs;
    assign dvp.hs_out         = r_hs;
    assign dvp.data_out       = r_data;
    assign dvp.frame_done_out = r_fd;
endmodule
